// File: rtl/l1_ahb_burst_arbiter.sv
// Address-phase arbiter for a two-input AHB matrix output stage.
// Round-robin between ports, holding the grant through fixed bursts, undefined INCR and locked sequences.
module l1_ahb_burst_arbiter (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_port0,
  input  logic       req_port1,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [1:0] addr_in_port,
  output logic       no_port
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [3:0] beat_cnt;
  logic [3:0] beat_cnt_nxt;
  logic [3:0] burst_load;
  logic       incr_hold;
  logic       incr_hold_nxt;
  logic       owner_req;
  logic       hold;
  logic       req_any;
  logic [1:0] grant_idx;

  always_comb begin
    case (HBURSTM)
      3'b010, 3'b011: burst_load = 4'd3;
      3'b100, 3'b101: burst_load = 4'd7;
      3'b110, 3'b111: burst_load = 4'd15;
      default:        burst_load = 4'd0;
    endcase
  end

  // Burst tracking for the current owner; an ungranted or deselected cycle ends any burst.
  always_comb begin
    beat_cnt_nxt  = beat_cnt;
    incr_hold_nxt = incr_hold;
    if (no_port || !HSELM || HTRANSM == TRANS_IDLE) begin
      beat_cnt_nxt  = 4'd0;
      incr_hold_nxt = 1'b0;
    end else if (HTRANSM == TRANS_NONSEQ) begin
      beat_cnt_nxt  = burst_load;
      incr_hold_nxt = (HBURSTM == 3'b001);
    end else if (HTRANSM == TRANS_SEQ && beat_cnt != 4'd0) begin
      beat_cnt_nxt = beat_cnt - 4'd1;
    end
  end

  assign owner_req = (addr_in_port == 2'b01) ? req_port1 : req_port0;

  assign hold = !no_port &&
                (HMASTLOCKM || beat_cnt_nxt != 4'd0 || HTRANSM == TRANS_BUSY ||
                 (incr_hold_nxt && owner_req));

  assign req_any = req_port0 | req_port1;

  always_comb begin
    grant_idx = addr_in_port;
    if (req_port0 && req_port1)
      grant_idx = (addr_in_port == 2'b01) ? 2'b00 : 2'b01;
    else if (req_port0)
      grant_idx = 2'b00;
    else if (req_port1)
      grant_idx = 2'b01;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= 2'b00;
      no_port      <= 1'b1;
      beat_cnt     <= 4'd0;
      incr_hold    <= 1'b0;
    end else if (HREADYM) begin
      if (hold) begin
        beat_cnt  <= beat_cnt_nxt;
        incr_hold <= incr_hold_nxt;
      end else if (!req_any) begin
        // addr_in_port keeps the last owner so rotation resumes fairly
        no_port   <= 1'b1;
        beat_cnt  <= 4'd0;
        incr_hold <= 1'b0;
      end else begin
        addr_in_port <= grant_idx;
        no_port      <= 1'b0;
        if (grant_idx != addr_in_port) begin
          beat_cnt  <= 4'd0;
          incr_hold <= 1'b0;
        end else begin
          beat_cnt  <= beat_cnt_nxt;
          incr_hold <= incr_hold_nxt;
        end
      end
    end
  end

endmodule
